// File: rtl/decode_pkg.sv
// Shared types and sizes for the decode byte queue.
package decode_pkg;
  localparam int unsigned QUEUE_BYTES = 16;
  localparam int unsigned FETCH_BYTES = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    S_FLUSH = 1'b0,
    S_RUN   = 1'b1
  } queue_state_t;
endpackage

// File: rtl/byte_shifter.sv
// Combinational window update: left shift by the retired length with zero fill,
// then overlay up to FETCH_BYTES fetched bytes starting at fetch_offset.
module byte_shifter
  import decode_pkg::byte_t;
#(
  parameter int unsigned QUEUE_BYTES = 16,
  parameter int unsigned FETCH_BYTES = 4
) (
  input  byte_t      window      [QUEUE_BYTES],
  input  logic [3:0] shift,
  input  logic       fetch_en,
  input  byte_t      fetch_bytes [FETCH_BYTES],
  input  logic [2:0] fetch_count,
  input  logic [4:0] fetch_offset,
  output byte_t      next_window [QUEUE_BYTES]
);

  logic [QUEUE_BYTES*8-1:0] flat;
  logic [QUEUE_BYTES*8-1:0] shifted;

  always_comb begin
    flat = '0;
    for (int i = 0; i < int'(QUEUE_BYTES); i++) begin
      flat[i*8 +: 8] = window[i];
    end
    // byte 0 sits in the low bits, so a right shift of the flat vector drops the oldest bytes
    shifted = flat >> {shift, 3'b000};
    for (int i = 0; i < int'(QUEUE_BYTES); i++) begin
      next_window[i] = shifted[i*8 +: 8];
      for (int j = 0; j < int'(FETCH_BYTES); j++) begin
        if (fetch_en && (j < int'(fetch_count)) && ((int'(fetch_offset) + j) == i)) begin
          next_window[i] = fetch_bytes[j];
        end
      end
    end
  end

endmodule

// File: rtl/decode_queue_controller.sv
// Front-aligned instruction byte queue feeding the decoder: accepts fetch beats,
// retires consumed bytes, and flushes on control transfers.
module decode_queue_controller
  import decode_pkg::byte_t;
  import decode_pkg::queue_state_t;
  import decode_pkg::S_FLUSH;
  import decode_pkg::S_RUN;
#(
  parameter int unsigned QUEUE_BYTES = 16,
  parameter int unsigned FETCH_BYTES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_flush,
  input  logic        i_fetch_valid,
  input  byte_t       i_fetch_bytes [FETCH_BYTES],
  input  logic [2:0]  i_fetch_count,
  output logic        o_fetch_ready,
  output byte_t       o_window [QUEUE_BYTES],
  output logic [4:0]  o_window_count,
  input  logic [4:0]  i_decode_need,
  output logic        o_window_valid,
  input  logic        i_consume_valid,
  input  logic [3:0]  i_consume_length,
  output logic [31:0] o_retired_count,
  output logic        o_error_underflow
);

  queue_state_t state;
  byte_t        next_window [QUEUE_BYTES];
  logic         consume_legal;
  logic         fetch_accept;
  logic [3:0]   shift;
  logic [4:0]   fetch_offset;
  logic [4:0]   next_count;

  assign o_fetch_ready  = (state == S_RUN) && !i_flush &&
                          (o_window_count <= 5'(QUEUE_BYTES - FETCH_BYTES));
  assign o_window_valid = (state == S_RUN) && (o_window_count >= i_decode_need);

  // Retire and fetch resolve together: fetched bytes land just above the survivors.
  always_comb begin
    consume_legal = i_consume_valid && ({1'b0, i_consume_length} <= o_window_count);
    fetch_accept  = i_fetch_valid && o_fetch_ready;
    shift         = consume_legal ? i_consume_length : 4'd0;
    fetch_offset  = o_window_count - {1'b0, shift};
    next_count    = fetch_offset + (fetch_accept ? {2'b00, i_fetch_count} : 5'd0);
  end

  byte_shifter #(
    .QUEUE_BYTES (QUEUE_BYTES),
    .FETCH_BYTES (FETCH_BYTES)
  ) u_byte_shifter (
    .window       (o_window),
    .shift        (shift),
    .fetch_en     (fetch_accept),
    .fetch_bytes  (i_fetch_bytes),
    .fetch_count  (i_fetch_count),
    .fetch_offset (fetch_offset),
    .next_window  (next_window)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= S_FLUSH;
      o_window_count    <= 5'd0;
      o_retired_count   <= 32'd0;
      o_error_underflow <= 1'b0;
      for (int i = 0; i < int'(QUEUE_BYTES); i++) begin
        o_window[i] <= 8'h00;
      end
    end else begin
      state <= (state == S_RUN && i_flush) ? S_FLUSH : S_RUN;
      if (i_flush) begin
        o_window_count <= 5'd0;
        for (int i = 0; i < int'(QUEUE_BYTES); i++) begin
          o_window[i] <= 8'h00;
        end
      end else begin
        o_window_count <= next_count;
        o_window       <= next_window;
        if (consume_legal) begin
          o_retired_count <= o_retired_count + 32'd1;
        end
        if (i_consume_valid && !consume_legal) begin
          o_error_underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_queue_controller.sv
// Directed bench for decode_queue_controller with hand-computed expectations.
module tb_decode_queue_controller;

  logic        clock;
  logic        reset;
  logic        i_flush;
  logic        i_fetch_valid;
  logic [7:0]  i_fetch_bytes [4];
  logic [2:0]  i_fetch_count;
  logic        o_fetch_ready;
  logic [7:0]  o_window [16];
  logic [4:0]  o_window_count;
  logic [4:0]  i_decode_need;
  logic        o_window_valid;
  logic        i_consume_valid;
  logic [3:0]  i_consume_length;
  logic [31:0] o_retired_count;
  logic        o_error_underflow;

  int errors = 0;
  int checks = 0;

  decode_queue_controller #(
    .QUEUE_BYTES (16),
    .FETCH_BYTES (4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .i_flush           (i_flush),
    .i_fetch_valid     (i_fetch_valid),
    .i_fetch_bytes     (i_fetch_bytes),
    .i_fetch_count     (i_fetch_count),
    .o_fetch_ready     (o_fetch_ready),
    .o_window          (o_window),
    .o_window_count    (o_window_count),
    .i_decode_need     (i_decode_need),
    .o_window_valid    (o_window_valid),
    .i_consume_valid   (i_consume_valid),
    .i_consume_length  (i_consume_length),
    .o_retired_count   (o_retired_count),
    .o_error_underflow (o_error_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [2:0] n);
    i_fetch_valid    = v;
    i_fetch_bytes[0] = b0;
    i_fetch_bytes[1] = b1;
    i_fetch_bytes[2] = b2;
    i_fetch_bytes[3] = b3;
    i_fetch_count    = n;
  endtask

  task automatic set_consume(input logic v, input logic [3:0] len);
    i_consume_valid  = v;
    i_consume_length = len;
  endtask

  initial begin
    reset         = 1'b0;
    i_flush       = 1'b0;
    i_decode_need = 5'd1;
    set_fetch(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    set_consume(1'b0, 4'd0);
    #1 reset = 1'b1;
    #2;
    check("rst_count", 32'(o_window_count), 32'd0);
    check("rst_win0", 32'(o_window[0]), 32'h00);
    check("rst_ready", 32'(o_fetch_ready), 32'd0);
    check("rst_valid", 32'(o_window_valid), 32'd0);
    check("rst_retired", o_retired_count, 32'd0);
    check("rst_err", 32'(o_error_underflow), 32'd0);
    #5 reset = 1'b0;
    check("flush_state_ready", 32'(o_fetch_ready), 32'd0);
    tick();
    check("run_ready", 32'(o_fetch_ready), 32'd1);

    // fill the window with 0x00..0x0F
    for (int b = 0; b < 4; b++) begin
      set_fetch(1'b1, 8'(b*4), 8'(b*4+1), 8'(b*4+2), 8'(b*4+3), 3'd4);
      tick();
    end
    set_fetch(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    check("fill_count", 32'(o_window_count), 32'd16);
    check("fill_ready", 32'(o_fetch_ready), 32'd0);
    check("fill_win0", 32'(o_window[0]), 32'h00);
    check("fill_win15", 32'(o_window[15]), 32'h0F);

    // full window: consume 5 while a refused fetch is offered
    set_fetch(1'b1, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 3'd3);
    set_consume(1'b1, 4'd5);
    check("full_ready", 32'(o_fetch_ready), 32'd0);
    tick();
    set_fetch(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    set_consume(1'b0, 4'd0);
    check("c5_count", 32'(o_window_count), 32'd11);
    check("c5_win0", 32'(o_window[0]), 32'h05);
    check("c5_win10", 32'(o_window[10]), 32'h0F);
    check("c5_win11", 32'(o_window[11]), 32'h00);
    check("c5_win15", 32'(o_window[15]), 32'h00);
    check("c5_retired", o_retired_count, 32'd1);

    // grow to 12, then consume 6 and fetch 4 in one edge
    set_fetch(1'b1, 8'h10, 8'h00, 8'h00, 8'h00, 3'd1);
    tick();
    check("c12_count", 32'(o_window_count), 32'd12);
    set_fetch(1'b1, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 3'd4);
    set_consume(1'b1, 4'd6);
    tick();
    set_fetch(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    set_consume(1'b0, 4'd0);
    check("cf_count", 32'(o_window_count), 32'd10);
    check("cf_win0", 32'(o_window[0]), 32'h0B);
    check("cf_win5", 32'(o_window[5]), 32'h10);
    check("cf_win6", 32'(o_window[6]), 32'hA0);
    check("cf_win9", 32'(o_window[9]), 32'hA3);
    check("cf_win10", 32'(o_window[10]), 32'h00);
    check("cf_retired", o_retired_count, 32'd2);

    // count 3 against need 4, then one more byte
    set_consume(1'b1, 4'd7);
    tick();
    set_consume(1'b0, 4'd0);
    i_decode_need = 5'd4;
    #1;
    check("n4_count", 32'(o_window_count), 32'd3);
    check("n4_win0", 32'(o_window[0]), 32'hA1);
    check("n4_valid", 32'(o_window_valid), 32'd0);
    set_fetch(1'b1, 8'h55, 8'h00, 8'h00, 8'h00, 3'd1);
    tick();
    set_fetch(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    check("n4_valid_after", 32'(o_window_valid), 32'd1);
    check("n4_win3", 32'(o_window[3]), 32'h55);
    check("n4_retired", o_retired_count, 32'd3);

    // exact-count consume is legal, over-length consume underflows
    set_consume(1'b1, 4'd2);
    tick();
    check("eq_count", 32'(o_window_count), 32'd2);
    check("eq_err", 32'(o_error_underflow), 32'd0);
    set_consume(1'b1, 4'd5);
    tick();
    set_consume(1'b0, 4'd0);
    check("uf_err", 32'(o_error_underflow), 32'd1);
    check("uf_count", 32'(o_window_count), 32'd2);
    check("uf_retired", o_retired_count, 32'd4);
    check("uf_win0", 32'(o_window[0]), 32'hA3);
    tick();
    check("uf_sticky", 32'(o_error_underflow), 32'd1);

    // build count 9, then flush over a fetch and consume
    set_fetch(1'b1, 8'h60, 8'h61, 8'h62, 8'h63, 3'd4);
    tick();
    set_fetch(1'b1, 8'h64, 8'h65, 8'h66, 8'h00, 3'd3);
    tick();
    check("f9_count", 32'(o_window_count), 32'd9);
    set_fetch(1'b1, 8'h77, 8'h77, 8'h77, 8'h77, 3'd4);
    set_consume(1'b1, 4'd3);
    i_flush = 1'b1;
    #1;
    check("fl_ready_now", 32'(o_fetch_ready), 32'd0);
    tick();
    i_flush = 1'b0;
    set_consume(1'b0, 4'd0);
    check("fl_count", 32'(o_window_count), 32'd0);
    check("fl_ready", 32'(o_fetch_ready), 32'd0);
    check("fl_win0", 32'(o_window[0]), 32'h00);
    check("fl_retired", o_retired_count, 32'd4);
    tick();
    check("fl_count2", 32'(o_window_count), 32'd0);
    check("fl_ready2", 32'(o_fetch_ready), 32'd1);
    tick();
    set_fetch(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    check("fl_refill", 32'(o_window_count), 32'd4);
    check("fl_refill_w0", 32'(o_window[0]), 32'h77);

    // asynchronous reset mid-fill
    set_fetch(1'b1, 8'h88, 8'h88, 8'h88, 8'h88, 3'd4);
    #2 reset = 1'b1;
    #1;
    set_fetch(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    check("ar_count", 32'(o_window_count), 32'd0);
    check("ar_win0", 32'(o_window[0]), 32'h00);
    check("ar_ready", 32'(o_fetch_ready), 32'd0);
    check("ar_valid", 32'(o_window_valid), 32'd0);
    check("ar_retired", o_retired_count, 32'd0);
    check("ar_err", 32'(o_error_underflow), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("ar_resume_ready", 32'(o_fetch_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
